video_pattern_gen: RTL and testbench

- Source-side counterpart to the video processing stage: generates the raster timing (fvht) and a 4:2:2 video stream ({luma, chroma}, 20 bits) that downstream blocks consume.
- Sits at the head of the video pipeline and replaces the external bars/colour source for bring-up and regression.
- Emits standard EAV/SAV timing reference words so that both fvht-edge-based and TRS-based receivers can lock.

---
 rtl/video_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_video_pattern_gen.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | video_pattern_gen: raster timing (fvht) and 4:2:2 test-pattern source     |
// | with EAV/SAV timing reference words.   Revision: 1.0                      |
// +--------------------------------------------------------------------------+
module video_pattern_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2200,
  parameter int V_ACTIVE = 1080,
  parameter int V_TOTAL  = 1125,
  parameter int BAR_W    = 240
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [29:0] flat_ycbcr_i,
  output logic [3:0]  fvht_o,
  output logic [19:0] video_o,
  output logic        sof_o
);

  localparam int        c_HC_W    = $clog2(H_TOTAL);
  localparam int        c_VC_W    = $clog2(V_TOTAL);
  localparam logic [9:0] c_BLK_Y  = 10'h040;
  localparam logic [9:0] c_BLK_C  = 10'h200;
  localparam logic [1:0] c_PAT_BARS = 2'd0;
  localparam logic [1:0] c_PAT_FLAT = 2'd1;
  localparam logic [1:0] c_PAT_RAMP = 2'd2;

  logic [c_HC_W-1:0] hc_q, hc_d;
  logic [c_VC_W-1:0] vc_q, vc_d;
  logic [1:0]        pat_q;
  logic [29:0]       flat_q;
  logic [3:0]        fvht_d;
  logic [19:0]       video_d;
  logic              sof_d;

  logic              w_line_end, w_frame_end;
  logic              w_h, w_v, w_eav, w_sav, w_t;
  logic [1:0]        w_trs_idx;
  logic [9:0]        w_xyz, w_trs_word;
  logic [2:0]        w_bar_idx;
  logic [29:0]       w_bar_ycc, w_pix_ycc;
  logic [10:0]       w_ramp;
  logic [9:0]        w_ramp_y;

  assign w_line_end  = (hc_q == c_HC_W'(H_TOTAL - 1));
  assign w_frame_end = w_line_end && (vc_q == c_VC_W'(V_TOTAL - 1));

  always_comb begin
    hc_d = hc_q + c_HC_W'(1);
    vc_d = vc_q;
    if (w_line_end) begin
      hc_d = '0;
      vc_d = (vc_q == c_VC_W'(V_TOTAL - 1)) ? '0 : vc_q + c_VC_W'(1);
    end
  end

  // Progressive source: F is always 0, so parity bits reduce accordingly.
  assign w_h     = (hc_q >= c_HC_W'(H_ACTIVE));
  assign w_v     = (vc_q >= c_VC_W'(V_ACTIVE));
  assign w_eav   = w_h && (hc_q <= c_HC_W'(H_ACTIVE + 3));
  assign w_sav   = (hc_q >= c_HC_W'(H_TOTAL - 4));
  assign w_t     = w_eav || w_sav;
  assign w_trs_idx = w_eav ? 2'(hc_q - c_HC_W'(H_ACTIVE))
                           : 2'(hc_q - c_HC_W'(H_TOTAL - 4));
  assign w_xyz   = {1'b1, 1'b0, w_v, w_eav, w_v ^ w_eav, w_eav, w_v,
                    w_v ^ w_eav, 2'b00};

  always_comb begin
    case (w_trs_idx)
      2'd0:    w_trs_word = 10'h3FF;
      2'd3:    w_trs_word = w_xyz;
      default: w_trs_word = 10'h000;
    endcase
  end

  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hc_q >= c_HC_W'(k * BAR_W)) w_bar_idx = 3'(k);
    end
  end

  always_comb begin
    case (w_bar_idx)
      3'd0:    w_bar_ycc = {10'd940, 10'd512, 10'd512};
      3'd1:    w_bar_ycc = {10'd877, 10'd64,  10'd553};
      3'd2:    w_bar_ycc = {10'd754, 10'd615, 10'd64};
      3'd3:    w_bar_ycc = {10'd691, 10'd167, 10'd105};
      3'd4:    w_bar_ycc = {10'd313, 10'd857, 10'd919};
      3'd5:    w_bar_ycc = {10'd250, 10'd409, 10'd960};
      3'd6:    w_bar_ycc = {10'd127, 10'd960, 10'd471};
      default: w_bar_ycc = {10'd64,  10'd512, 10'd512};
    endcase
    if (hc_q >= c_HC_W'(8 * BAR_W)) w_bar_ycc = {10'd64, 10'd512, 10'd512};
  end

  assign w_ramp   = 11'd64 + 11'(hc_q >> 1);
  assign w_ramp_y = (w_ramp > 11'd940) ? 10'd940 : w_ramp[9:0];

  always_comb begin
    case (pat_q)
      c_PAT_BARS: w_pix_ycc = w_bar_ycc;
      c_PAT_FLAT: w_pix_ycc = flat_q;
      c_PAT_RAMP: w_pix_ycc = {w_ramp_y, 10'd512, 10'd512};
      default:    w_pix_ycc = {10'd64, 10'd512, 10'd512};
    endcase
  end

  always_comb begin
    fvht_d = {1'b0, w_v, w_h, w_t};
    sof_d  = (hc_q == '0) && (vc_q == '0);
    if (w_t) begin
      video_d = {w_trs_word, w_trs_word};
    end else if (w_h || w_v) begin
      video_d = {c_BLK_Y, c_BLK_C};
    end else begin
      // Even samples carry Cb, odd samples carry Cr.
      video_d = {w_pix_ycc[29:20], hc_q[0] ? w_pix_ycc[9:0] : w_pix_ycc[19:10]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc_q    <= '0;
      vc_q    <= '0;
      pat_q   <= c_PAT_BARS;
      flat_q  <= '0;
      fvht_o  <= 4'b0000;
      video_o <= {c_BLK_Y, c_BLK_C};
      sof_o   <= 1'b0;
    end else if (cen_i) begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fvht_o  <= fvht_d;
      video_o <= video_d;
      sof_o   <= sof_d;
      // Latch the pattern only at frame end so a new selection never tears.
      if (w_frame_end) begin
        pat_q  <= pat_sel_i;
        flat_q <= flat_ycbcr_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_video_pattern_gen: directed self-checking bench for video_pattern_gen  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_video_pattern_gen;

  localparam int HT = 2200;
  localparam int HA = 1920;
  localparam int VA = 3;
  localparam int VT = 5;
  localparam int FR = HT * VT;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cen_i = 1'b0;
  logic [1:0]  pat_sel_i = 2'd0;
  logic [29:0] flat_ycbcr_i = '0;
  logic [3:0]  fvht_o;
  logic [19:0] video_o;
  logic        sof_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_edges  = 0;
  int sof_cnt  = 0;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT), .BAR_W(240)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .pat_sel_i(pat_sel_i),
    .flat_ycbcr_i(flat_ycbcr_i), .fvht_o(fvht_o), .video_o(video_o), .sof_o(sof_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] f, input logic [9:0] y,
                            input logic [9:0] c, input logic s);
    check({tag, ".fvht"},  32'(fvht_o),  32'(f));
    check({tag, ".video"}, 32'(video_o), 32'({y, c}));
    check({tag, ".sof"},   32'(sof_o),   32'(s));
  endtask

  task automatic step();
    cen_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_edges++;
    if (sof_o) sof_cnt++;
  endtask

  task automatic hold();
    cen_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  // Advance until the registered outputs reflect raster position (h, v) of frame f.
  task automatic goto_pos(input int f, input int h, input int v);
    int tgt;
    tgt = f * FR + v * HT + h + 1;
    while (n_edges < tgt) step();
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    expect_out("reset", 4'b0000, 10'h040, 10'h200, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;

    goto_pos(0, 0, 0);    expect_out("first", 4'b0000, 10'd940, 10'd512, 1'b1);
    goto_pos(0, 1, 0);    expect_out("cr1",   4'b0000, 10'd940, 10'd512, 1'b0);
    goto_pos(0, 240, 0);  expect_out("yel",   4'b0000, 10'd877, 10'd64,  1'b0);
    goto_pos(0, 1919, 0); expect_out("blk",   4'b0000, 10'd64,  10'd512, 1'b0);
    goto_pos(0, 1920, 0); expect_out("eav0",  4'b0011, 10'h3FF, 10'h3FF, 1'b0);
    goto_pos(0, 1921, 0); expect_out("eav1",  4'b0011, 10'h000, 10'h000, 1'b0);
    goto_pos(0, 1922, 0); expect_out("eav2",  4'b0011, 10'h000, 10'h000, 1'b0);
    goto_pos(0, 1923, 0); expect_out("eav3",  4'b0011, 10'h274, 10'h274, 1'b0);
    goto_pos(0, 1924, 0); expect_out("hblk",  4'b0010, 10'h040, 10'h200, 1'b0);
    goto_pos(0, 2196, 0); expect_out("sav0",  4'b0011, 10'h3FF, 10'h3FF, 1'b0);
    goto_pos(0, 2199, 0); expect_out("sav3",  4'b0011, 10'h200, 10'h200, 1'b0);
    goto_pos(0, 0, 1);    expect_out("line1", 4'b0000, 10'd940, 10'd512, 1'b0);
    // First vertical-blanking line: V=1 in both EAV (H=1) and SAV (H=0).
    goto_pos(0, 0, VA);    expect_out("vblk",  4'b0100, 10'h040, 10'h200, 1'b0);
    goto_pos(0, 1923, VA); expect_out("veav3", 4'b0111, 10'h2D8, 10'h2D8, 1'b0);
    goto_pos(0, 2199, VA); expect_out("vsav3", 4'b0111, 10'h2AC, 10'h2AC, 1'b0);
    goto_pos(0, 2199, VT-1); expect_out("vlast", 4'b0111, 10'h2AC, 10'h2AC, 1'b0);
    goto_pos(1, 0, 0);    expect_out("frame1", 4'b0000, 10'd940, 10'd512, 1'b1);
    check("sof_count", 32'(sof_cnt), 32'd2);

    goto_pos(1, 240, 0);  expect_out("cen_a", 4'b0000, 10'd877, 10'd64,  1'b0);
    hold();               expect_out("cen_h1", 4'b0000, 10'd877, 10'd64,  1'b0);
    step();               expect_out("cen_b", 4'b0000, 10'd877, 10'd553, 1'b0);
    hold();               expect_out("cen_h2", 4'b0000, 10'd877, 10'd553, 1'b0);
    step();               expect_out("cen_c", 4'b0000, 10'd877, 10'd64,  1'b0);
    check("cen_pos", 32'(n_edges), 32'(FR + 242 + 1));

    goto_pos(1, 0, 1);
    pat_sel_i = 2'd1;
    flat_ycbcr_i = {10'd500, 10'd300, 10'd700};
    goto_pos(1, 0, 2);    expect_out("nosw",  4'b0000, 10'd940, 10'd512, 1'b0);
    goto_pos(2, 0, 0);    expect_out("flat0", 4'b0000, 10'd500, 10'd300, 1'b1);
    goto_pos(2, 1, 0);    expect_out("flat1", 4'b0000, 10'd500, 10'd700, 1'b0);

    pat_sel_i = 2'd2;
    goto_pos(2, 0, 1);    expect_out("flat2", 4'b0000, 10'd500, 10'd300, 1'b0);
    goto_pos(3, 0, 0);    expect_out("ramp0",    4'b0000, 10'd64,  10'd512, 1'b1);
    goto_pos(3, 100, 0);  expect_out("ramp100",  4'b0000, 10'd114, 10'd512, 1'b0);
    goto_pos(3, 1751, 0); expect_out("ramp1751", 4'b0000, 10'd939, 10'd512, 1'b0);
    goto_pos(3, 1752, 0); expect_out("ramp1752", 4'b0000, 10'd940, 10'd512, 1'b0);
    goto_pos(3, 1920, 0); expect_out("ramp_eav", 4'b0011, 10'h3FF, 10'h3FF, 1'b0);

    pat_sel_i = 2'd3;
    goto_pos(3, 1000, 1); expect_out("ramp1000", 4'b0000, 10'd564, 10'd512, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    expect_out("async_rst", 4'b0000, 10'h040, 10'h200, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    expect_out("rst_hold", 4'b0000, 10'h040, 10'h200, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    n_edges = 0;
    step();               expect_out("restart", 4'b0000, 10'd940, 10'd512, 1'b1);
    step();               expect_out("restart1", 4'b0000, 10'd940, 10'd512, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
